seq_det_mealy_0011: RTL and testbench
=====================================

// Module: seq_det_mealy_0011
// PURPOSE
//   Serial-bit Mealy detector for the pattern 0-0-1-1, oldest bit first.
//   Samples one input bit w per rising Clock edge.
//   Asserts z combinationally during the cycle in which the final '1' of 0011 is present on w.
//   Leaf block used as the top of the sequence-detector design; no handshake, no back-pressure.
// PARAMETERS
//   COUNT_W   8   width of the match counter; only used when SEQ_DET_MATCH_CNT_EN is defined.
// PORTS
//   Clock        in   1        single clock; all state updates on rising edge.
//   Resetn       in   1        asynchronous, active-low reset.
//   w            in   1        serial data bit, sampled on rising Clock.
//   z            out  1        Mealy detect output; high while state==S3 && w==1.
//   match_count  out  COUNT_W  matches detected; port exists only with SEQ_DET_MATCH_CNT_EN.
// BEHAVIOUR
//   Reset and clocking:
//   - One clock, Clock; reset Resetn is asynchronous and active-low.
//   - Resetn=0 forces state=S0 immediately, independent of Clock.
//   - z is 0 while in reset because S0 never drives z.
//   - Reset asserted mid-sequence discards all partial progress.
//   - On the first edge after release, w is treated as a fresh first bit.
//   States (2-bit encoding):
//     S0 = nothing matched, S1 = "0", S2 = "00", S3 = "001".
//   Transitions (next-state / z) for w=0 | w=1:
//     S0: S1/0 | S0/0
//     S1: S2/0 | S0/0
//     S2: S2/0 | S3/0   (extra leading zeros stay in S2)
//     S3: S1/0 | S0/1   (match; "0011" has no proper prefix that is also a suffix, so go to S0)
//   Overlap and latency:
//   - Overlapping detection is supported; "0010011" detects once, on the last bit.
//   - z = (state==S3) & w, purely combinational, zero-cycle latency from w.
//   - z is valid before the edge that consumes the bit; it glitches with w.
//   X handling: w=X while Resetn=0 is don't-care; no assertion is required.
// CONFIGURATION
//   Macro: SEQ_DET_MATCH_CNT_EN
//   - Defined: adds match_count register.
//     - Async reset to 0.
//     - Increments on each rising Clock where z==1.
//     - Saturates at all-ones; does not wrap.
//   - Undefined: port and register absent; only the FSM and z exist.
// STRUCTURE
//   Package seq_det_pkg:
//   - typedef enum logic[1:0] state_t {S0,S1,S2,S3}
//   - localparam PATTERN = 4'b0011
//   - localparam PAT_LEN = 4
//   Sub-module seq_det_mealy_0011_core:
//   - Contents: state register, next-state logic, Mealy z.
//   - This top instantiates it and adds the optional counter.
// TESTING
//   T1: Resetn=0 for part of a cycle, then release; w=0,0,0,1,1 on successive edges
//       -> z=0 for the first four bits; z=1 while the 2nd '1' is applied (state S3).
//   T2: w=0,0,1,1,0,0,1,1 -> z=1 exactly on bit 4 and bit 8; next state S0 after each.
//   T3: w=1,1,1,0,1,1 -> z never asserts ("011" alone is insufficient).
//   T4: w=0,0,0,0,0,1,1 -> long zero run stays in S2; z=1 on the final bit only.
//   T5: w=0,0,1, then Resetn=0 asynchronously mid-cycle, release, w=1
//       -> state S0 immediately on reset; no detect on the trailing '1'.
//   T6 (SEQ_DET_MATCH_CNT_EN, COUNT_W=2): apply "0011" five times
//       -> match_count =1,2,3,3,3 (saturates at 3); reset returns it to 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 0011 Mealy sequence detector.
package seq_det_pkg;

   typedef enum logic [1:0] {
      S0 = 2'd0,  // nothing matched
      S1 = 2'd1,  // "0"
      S2 = 2'd2,  // "00"
      S3 = 2'd3   // "001"
   } state_t;

   localparam int                 PAT_LEN = 4;
   localparam logic [PAT_LEN-1:0] PATTERN = 4'b0011;  // MSB is the oldest bit

endpackage

// File: rtl/seq_det_mealy_0011_core.sv
// State register, next-state logic and Mealy output for the 0011 detector.
module seq_det_mealy_0011_core
   import seq_det_pkg::*;
(
   input  logic Clock,
   input  logic Resetn,
   input  logic w,
   output logic z
);

   state_t state;
   state_t state_next;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs, independent of process ordering.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= S0;
      end else begin
         state <= state_next;
      end
   end

   // Fallback targets are specific to 0011: a stray '1' early on restarts,
   // extra zeros keep "00", and neither a mismatch nor a match at S3 leaves
   // any reusable suffix beyond a single "0".
   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_next = state;
      z          = 1'b0;
      unique case (state)
         S0: state_next = (w == PATTERN[3]) ? S1 : S0;
         S1: state_next = (w == PATTERN[2]) ? S2 : S0;
         S2: state_next = (w == PATTERN[1]) ? S3 : S2;
         S3: begin
            if (w == PATTERN[0]) begin
               state_next = S0;
               z          = 1'b1;
            end else begin
               state_next = S1;
            end
         end
         default: state_next = S0;
      endcase
   end

endmodule

// File: rtl/seq_det_mealy_0011.sv
// Top of the serial 0011 Mealy detector (overlapping, zero-latency z).
// Define SEQ_DET_MATCH_CNT_EN to add the saturating match_count output (COUNT_W bits).
module seq_det_mealy_0011
   import seq_det_pkg::*;
`ifdef SEQ_DET_MATCH_CNT_EN
#(
   parameter int COUNT_W = 8
)
`endif
(
   input  logic Clock,
   input  logic Resetn,
   input  logic w,
   output logic z
`ifdef SEQ_DET_MATCH_CNT_EN
   ,
   output logic [COUNT_W-1:0] match_count
`endif
);

   seq_det_mealy_0011_core u_core (
      .Clock  (Clock),
      .Resetn (Resetn),
      .w      (w),
      .z      (z)
   );

`ifdef SEQ_DET_MATCH_CNT_EN
   // Counts edges that consume a matching bit; holds at all-ones.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         match_count <= '0;
      end else if (z && (match_count != '1)) begin
         match_count <= match_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_seq_det_mealy_0011.sv
// Self-checking bench for seq_det_mealy_0011: directed cases plus random bits
// compared against a bit-history reference model.
module tb_seq_det_mealy_0011;

   localparam logic [3:0] REF_PAT = 4'b0011;  // oldest bit first

   logic Clock = 1'b0;
   logic Resetn;
   logic w;
   logic z;

   int checks = 0;
   int errors = 0;

   // Reference model state: bits consumed since the last reset.
   bit hist[$];

`ifdef SEQ_DET_MATCH_CNT_EN
   localparam int CW = 2;
   logic [CW-1:0] match_count;
   int            exp_cnt = 0;

   seq_det_mealy_0011 #(.COUNT_W(CW)) dut (
      .Clock       (Clock),
      .Resetn      (Resetn),
      .w           (w),
      .z           (z),
      .match_count (match_count)
   );
`else
   seq_det_mealy_0011 dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .w      (w),
      .z      (z)
   );
`endif

   always #5 Clock = ~Clock;

   // A match is present when the last four bits since reset, including the
   // bit currently on w, spell the pattern.
   function automatic logic model_z(input logic b);
      bit win[$];
      win = hist;
      win.push_back(b);
      if (win.size() < 4) return 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (win[win.size() - 4 + i] != REF_PAT[3 - i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
`ifdef SEQ_DET_MATCH_CNT_EN
      exp_cnt = 0;
`endif
   endtask

   task automatic check_count(input string tag);
`ifdef SEQ_DET_MATCH_CNT_EN
      check(tag, 32'(match_count), 32'(exp_cnt));
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   // Drive one bit mid-low-phase, check z before the consuming edge, then
   // advance the model and check the counter after the edge.
   task automatic apply_bit(input logic b, output logic hit);
      logic exp_z;
      @(negedge Clock);
      w = b;
      #1;
      exp_z = model_z(b);
      check("z", 32'(z), 32'(exp_z));
      @(posedge Clock);
      hist.push_back(b);
      if (hist.size() > 4) void'(hist.pop_front());
`ifdef SEQ_DET_MATCH_CNT_EN
      if (exp_z && exp_cnt < (1 << CW) - 1) exp_cnt++;
`endif
      #1;
      check_count("match_count");
      hit = exp_z;
   endtask

   task automatic apply_str(input string s, output int hits);
      logic h;
      hits = 0;
      for (int i = 0; i < s.len(); i++) begin
         apply_bit(s[i] == "1", h);
         if (h) hits++;
      end
   endtask

   // Reset pulse entirely inside the low phase: no clock edge sees it,
   // so only an asynchronous reset can clear the state.
   task automatic short_reset();
      @(negedge Clock);
      #2 Resetn = 1'b0;
      #1;
      model_reset();
      check("z_in_reset", 32'(z), 32'd0);
      check_count("count_in_reset");
      #1 Resetn = 1'b1;
   endtask

   initial begin
      int   hits;
      logic h;

      // T1: reset from time zero, released within a low phase.
      Resetn = 1'b0;
      w      = 1'b0;
      #1;
      check("z_reset_t0", 32'(z), 32'd0);
      short_reset();
      apply_str("0001", hits);
      check("T1_prefix_hits", 32'(hits), 32'd0);
      apply_bit(1'b1, h);
      check("T1_final_hit", 32'(h), 32'd1);

      // T2: back-to-back patterns, detect on bits 4 and 8.
      short_reset();
      apply_str("00110011", hits);
      check("T2_hits", 32'(hits), 32'd2);

      // T3: "011" alone never matches.
      short_reset();
      apply_str("111011", hits);
      check("T3_hits", 32'(hits), 32'd0);

      // T4: long zero run, match on final bit only.
      short_reset();
      apply_str("000001", hits);
      check("T4_prefix_hits", 32'(hits), 32'd0);
      apply_bit(1'b1, h);
      check("T4_final_hit", 32'(h), 32'd1);

      // Overlap case: "0010011" detects once.
      short_reset();
      apply_str("0010011", hits);
      check("overlap_hits", 32'(hits), 32'd1);

      // T5: reach "001", present the '1', then reset asynchronously.
      short_reset();
      apply_str("001", hits);
      @(negedge Clock);
      w = 1'b1;
      #1;
      check("T5_z_before_reset", 32'(z), 32'd1);
      #1 Resetn = 1'b0;
      #1;
      model_reset();
      check("T5_z_async_reset", 32'(z), 32'd0);
      @(posedge Clock);
      #1;
      check("T5_z_held_reset", 32'(z), 32'd0);
      check_count("T5_count_reset");
      @(negedge Clock);
      Resetn = 1'b1;
      apply_bit(1'b1, h);
      check("T5_trailing_one", 32'(h), 32'd0);

`ifdef SEQ_DET_MATCH_CNT_EN
      // T6: counter saturates at 3 with COUNT_W=2, reset clears it.
      short_reset();
      for (int k = 0; k < 5; k++) begin
         apply_str("0011", hits);
         check("T6_count", 32'(match_count), (k < 3) ? 32'(k + 1) : 32'd3);
      end
      short_reset();
      check("T6_count_cleared", 32'(match_count), 32'd0);
`endif

      // Random bits with occasional asynchronous resets.
      short_reset();
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 59) == 0) begin
            short_reset();
         end else begin
            apply_bit(logic'($urandom_range(0, 2) == 0), h);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
